// File: rtl/io_scheduler_if.sv
// Request/response bundle and memory-port bundle shared by io_scheduler and its environment.
// The slave modport is the scheduler's view; the master modport is the devices-plus-memory view.
interface io_scheduler_if #(
    parameter int unsigned IO_COUNT  = 4,
    parameter int unsigned WORD_SIZE = 16
);
    logic [IO_COUNT-1:0]                req_valid;
    logic [IO_COUNT-1:0]                req_dir;
    logic [IO_COUNT-1:0][WORD_SIZE-1:0] req_addr;
    logic [IO_COUNT-1:0][WORD_SIZE-1:0] req_data;
    logic [IO_COUNT-1:0]                req_ready;
    logic [IO_COUNT-1:0]                rsp_valid;
    logic [WORD_SIZE-1:0]               rsp_data;
    logic                               busy;
    logic                               mem_en;
    logic                               mem_we;
    logic [WORD_SIZE-1:0]               mem_add;
    logic [WORD_SIZE-1:0]               mem_wr_data;
    logic [WORD_SIZE-1:0]               mem_rd_data;

    modport slave (
        input  req_valid, req_dir, req_addr, req_data, mem_rd_data,
        output req_ready, rsp_valid, rsp_data, busy, mem_en, mem_we, mem_add, mem_wr_data
    );

    modport master (
        output req_valid, req_dir, req_addr, req_data, mem_rd_data,
        input  req_ready, rsp_valid, rsp_data, busy, mem_en, mem_we, mem_add, mem_wr_data
    );
endinterface

// File: rtl/io_scheduler.sv
// Round-robin scheduler sharing one memory port between IO requesters (grant/issue/wait/done).
// Build macro IO_SCHED_PRIO0_EN gives requester 0 fixed priority over the round-robin ring.
module io_scheduler #(
    parameter int unsigned IO_COUNT       = 4,
    parameter int unsigned WORD_SIZE      = 16,
    parameter int unsigned MEM_RD_LATENCY = 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    io_scheduler_if.slave bus
);
    // Direction encoding: 1 = write to memory (IO_IN), 0 = read from memory (IO_OUT).
    localparam logic IO_IN = 1'b1;
    localparam int unsigned PtrW = (IO_COUNT > 2) ? $clog2(IO_COUNT) : 1;
    localparam int unsigned CntW = (MEM_RD_LATENCY > 2) ? $clog2(MEM_RD_LATENCY) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(MEM_RD_LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e               r_state;
    state_e               w_state_next;
    logic [PtrW-1:0]      r_ptr;
    logic [PtrW-1:0]      r_sel;
    logic                 r_dir;
    logic [WORD_SIZE-1:0] r_addr;
    logic [WORD_SIZE-1:0] r_wdata;
    logic [WORD_SIZE-1:0] r_rsp_data;
    logic [CntW-1:0]      r_cnt;

    logic                 w_found;
    logic                 w_prio;
    logic [PtrW-1:0]      w_winner;
    logic                 w_grant;
    logic                 w_busy;
    logic                 w_mem_en;
    logic                 w_mem_we;
    logic [IO_COUNT-1:0]  w_rsp_valid;

    // Pointer arithmetic modulo IO_COUNT; base is always < IO_COUNT.
    function automatic logic [PtrW-1:0] rr_index(input logic [PtrW-1:0] base,
                                                 input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= IO_COUNT) sum = sum - IO_COUNT;
        return PtrW'(sum);
    endfunction

    function automatic logic [IO_COUNT-1:0] onehot(input logic [PtrW-1:0] idx);
        logic [IO_COUNT-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_prio   = 1'b0;
        for (int unsigned k = 0; k < IO_COUNT; k++) begin
            if (!w_found && bus.req_valid[rr_index(r_ptr, k)]) begin
                w_found  = 1'b1;
                w_winner = rr_index(r_ptr, k);
            end
        end
`ifdef IO_SCHED_PRIO0_EN
        if (bus.req_valid[0]) begin
            w_found  = 1'b1;
            w_winner = '0;
            w_prio   = 1'b1;
        end
`else
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= StIdle;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_found) w_state_next = StIssue;
            StIssue: w_state_next = (r_dir == IO_IN) ? StDone : StWait;
            StWait:  if (r_cnt == '0) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Every strobe is masked while reset is high, whatever state the FSM was in.
    always_comb begin
        w_grant     = 1'b0;
        w_busy      = 1'b0;
        w_mem_en    = 1'b0;
        w_mem_we    = 1'b0;
        w_rsp_valid = '0;
        if (!i_rst) begin
            unique case (r_state)
                StIdle:  w_grant = w_found;
                StIssue: begin
                    w_busy   = 1'b1;
                    w_mem_en = 1'b1;
                    w_mem_we = (r_dir == IO_IN);
                end
                StWait:  w_busy = 1'b1;
                StDone:  begin
                    w_busy      = 1'b1;
                    w_rsp_valid = onehot(r_sel);
                end
                default: w_busy = 1'b0;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr      <= '0;
            r_sel      <= '0;
            r_dir      <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rsp_data <= '0;
            r_cnt      <= '0;
        end else begin
            if (w_grant) begin
                r_sel   <= w_winner;
                r_dir   <= bus.req_dir[w_winner];
                r_addr  <= bus.req_addr[w_winner];
                r_wdata <= bus.req_data[w_winner];
                r_ptr   <= w_prio ? r_ptr : rr_index(w_winner, 1);
            end
            if (r_state == StIssue) begin
                r_cnt <= CntLoad;
            end else if (r_state == StWait && r_cnt != '0) begin
                r_cnt <= r_cnt - CntW'(1);
            end
            if (r_state == StWait && r_cnt == '0) r_rsp_data <= bus.mem_rd_data;
        end
    end

    assign bus.req_ready   = w_grant ? onehot(w_winner) : '0;
    assign bus.rsp_valid   = w_rsp_valid;
    assign bus.rsp_data    = r_rsp_data;
    assign bus.busy        = w_busy;
    assign bus.mem_en      = w_mem_en;
    assign bus.mem_we      = w_mem_we;
    assign bus.mem_add     = r_addr;
    assign bus.mem_wr_data = r_wdata;
endmodule

// File: tb/tb_io_scheduler.sv
// Directed bench for io_scheduler: per-cycle vector table plus hand-written arbitration sequence.
// Direction bit 1 = write to memory, 0 = read; IO_COUNT=4, WORD_SIZE=16, MEM_RD_LATENCY=2.
module tb_io_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    io_scheduler_if #(.IO_COUNT(4), .WORD_SIZE(16)) bus ();

    io_scheduler #(.IO_COUNT(4), .WORD_SIZE(16), .MEM_RD_LATENCY(2)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  val;
        logic [3:0]  dir;
        logic [15:0] rd;
        logic        chk;
        logic [3:0]  rdy;
        logic [3:0]  rsp;
        logic        en;
        logic        we;
        logic        busy;
        logic [15:0] add;
        logic [15:0] wd;
        logic [15:0] rdat;
    } vec_t;

    vec_t vecs[$];

    function automatic void row(logic r, logic [3:0] val, logic [3:0] dir, logic [15:0] rd,
                                logic chk, logic [3:0] rdy, logic [3:0] rsp, logic en,
                                logic we, logic busy, logic [15:0] add, logic [15:0] wd,
                                logic [15:0] rdat);
        vec_t v;
        v = '{r, val, dir, rd, chk, rdy, rsp, en, we, busy, add, wd, rdat};
        vecs.push_back(v);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [6:0]  act, exp;
        logic [47:0] act_d, exp_d;
        logic [3:0]  exp_g;
        int          n;
        bit          got;

        bus.req_valid   = '0;
        bus.req_dir     = '0;
        bus.mem_rd_data = '0;
        bus.req_addr[0] = 16'h0100; bus.req_data[0] = 16'h1111;
        bus.req_addr[1] = 16'h0020; bus.req_data[1] = 16'h2222;
        bus.req_addr[2] = 16'h0010; bus.req_data[2] = 16'hBEEF;
        bus.req_addr[3] = 16'h0300; bus.req_data[3] = 16'h4444;

        // rst val dir rd chk | rdy rsp en we busy add wd rsp_data
        row(1, 4'hF, 4'hF, 16'h0, 0, 4'h0, 4'h0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        row(1, 4'hF, 4'hF, 16'h0, 1, 4'h0, 4'h0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        row(0, 4'hF, 4'hF, 16'h0, 1, 4'h1, 4'h0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        row(0, 4'hF, 4'hF, 16'h0, 1, 4'h0, 4'h0, 1, 1, 1, 16'h0100, 16'h1111, 16'h0000);
        row(0, 4'hF, 4'hF, 16'h0, 1, 4'h0, 4'h1, 0, 0, 1, 16'h0100, 16'h1111, 16'h0000);
        row(0, 4'hF, 4'hF, 16'h0, 1, 4'h2, 4'h0, 0, 0, 0, 16'h0100, 16'h1111, 16'h0000);
        row(0, 4'hF, 4'hF, 16'h0, 1, 4'h0, 4'h0, 1, 1, 1, 16'h0020, 16'h2222, 16'h0000);
        row(0, 4'hF, 4'hF, 16'h0, 1, 4'h0, 4'h2, 0, 0, 1, 16'h0020, 16'h2222, 16'h0000);
        row(0, 4'hF, 4'hF, 16'h0, 1, 4'h4, 4'h0, 0, 0, 0, 16'h0020, 16'h2222, 16'h0000);
        row(0, 4'hF, 4'hF, 16'h0, 1, 4'h0, 4'h0, 1, 1, 1, 16'h0010, 16'hBEEF, 16'h0000);
        row(0, 4'hF, 4'hF, 16'h0, 1, 4'h0, 4'h4, 0, 0, 1, 16'h0010, 16'hBEEF, 16'h0000);
        row(0, 4'hF, 4'hF, 16'h0, 1, 4'h8, 4'h0, 0, 0, 0, 16'h0010, 16'hBEEF, 16'h0000);
        row(0, 4'hF, 4'hF, 16'h0, 1, 4'h0, 4'h0, 1, 1, 1, 16'h0300, 16'h4444, 16'h0000);
        row(0, 4'hF, 4'hF, 16'h0, 1, 4'h0, 4'h8, 0, 0, 1, 16'h0300, 16'h4444, 16'h0000);
        row(0, 4'hF, 4'hF, 16'h0, 1, 4'h1, 4'h0, 0, 0, 0, 16'h0300, 16'h4444, 16'h0000);
        row(0, 4'h0, 4'hF, 16'h0, 1, 4'h0, 4'h0, 1, 1, 1, 16'h0100, 16'h1111, 16'h0000);
        row(0, 4'h0, 4'hF, 16'h0, 1, 4'h0, 4'h1, 0, 0, 1, 16'h0100, 16'h1111, 16'h0000);
        row(0, 4'h0, 4'hF, 16'h0, 1, 4'h0, 4'h0, 0, 0, 0, 16'h0100, 16'h1111, 16'h0000);
        // read by requester 1, memory data valid two cycles after the issue cycle
        row(0, 4'h2, 4'h0, 16'h0, 1, 4'h2, 4'h0, 0, 0, 0, 16'h0100, 16'h1111, 16'h0000);
        row(0, 4'h0, 4'h0, 16'h0, 1, 4'h0, 4'h0, 1, 0, 1, 16'h0020, 16'h2222, 16'h0000);
        row(0, 4'h0, 4'h0, 16'hDEAD, 1, 4'h0, 4'h0, 0, 0, 1, 16'h0020, 16'h2222, 16'h0000);
        row(0, 4'h0, 4'h0, 16'h1234, 1, 4'h0, 4'h0, 0, 0, 1, 16'h0020, 16'h2222, 16'h0000);
        row(0, 4'h0, 4'h0, 16'h0, 1, 4'h0, 4'h2, 0, 0, 1, 16'h0020, 16'h2222, 16'h1234);
        row(0, 4'h0, 4'h0, 16'h0, 1, 4'h0, 4'h0, 0, 0, 0, 16'h0020, 16'h2222, 16'h1234);
        // pointer skip: grant 0 leaves ptr=1, then only 3 and 0 valid
        row(0, 4'h1, 4'hF, 16'h0, 1, 4'h1, 4'h0, 0, 0, 0, 16'h0020, 16'h2222, 16'h1234);
        row(0, 4'h9, 4'hF, 16'h0, 1, 4'h0, 4'h0, 1, 1, 1, 16'h0100, 16'h1111, 16'h1234);
        row(0, 4'h9, 4'hF, 16'h0, 1, 4'h0, 4'h1, 0, 0, 1, 16'h0100, 16'h1111, 16'h1234);
        row(0, 4'h9, 4'hF, 16'h0, 1, 4'h8, 4'h0, 0, 0, 0, 16'h0100, 16'h1111, 16'h1234);
        row(0, 4'h9, 4'hF, 16'h0, 1, 4'h0, 4'h0, 1, 1, 1, 16'h0300, 16'h4444, 16'h1234);
        row(0, 4'h9, 4'hF, 16'h0, 1, 4'h0, 4'h8, 0, 0, 1, 16'h0300, 16'h4444, 16'h1234);
        row(0, 4'h9, 4'hF, 16'h0, 1, 4'h1, 4'h0, 0, 0, 0, 16'h0300, 16'h4444, 16'h1234);
        row(0, 4'h0, 4'hF, 16'h0, 1, 4'h0, 4'h0, 1, 1, 1, 16'h0100, 16'h1111, 16'h1234);
        row(0, 4'h0, 4'hF, 16'h0, 1, 4'h0, 4'h1, 0, 0, 1, 16'h0100, 16'h1111, 16'h1234);
        row(0, 4'h0, 4'hF, 16'h0, 1, 4'h0, 4'h0, 0, 0, 0, 16'h0100, 16'h1111, 16'h1234);
        // reset during the wait of a read aborts it silently and clears ptr
        row(0, 4'h4, 4'h0, 16'h0, 1, 4'h4, 4'h0, 0, 0, 0, 16'h0100, 16'h1111, 16'h1234);
        row(0, 4'h0, 4'h0, 16'h0, 1, 4'h0, 4'h0, 1, 0, 1, 16'h0010, 16'hBEEF, 16'h1234);
        row(1, 4'h0, 4'h0, 16'h0, 1, 4'h0, 4'h0, 0, 0, 0, 16'h0010, 16'hBEEF, 16'h1234);
        row(0, 4'h0, 4'h0, 16'h0, 1, 4'h0, 4'h0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        row(0, 4'h0, 4'h0, 16'h5555, 1, 4'h0, 4'h0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        row(0, 4'hA, 4'hF, 16'h0, 1, 4'h2, 4'h0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        // requester 3 raises then withdraws while the scheduler is busy
        row(0, 4'h8, 4'hF, 16'h0, 1, 4'h0, 4'h0, 1, 1, 1, 16'h0020, 16'h2222, 16'h0000);
        row(0, 4'h0, 4'hF, 16'h0, 1, 4'h0, 4'h2, 0, 0, 1, 16'h0020, 16'h2222, 16'h0000);
        row(0, 4'h0, 4'hF, 16'h0, 1, 4'h0, 4'h0, 0, 0, 0, 16'h0020, 16'h2222, 16'h0000);

`ifndef IO_SCHED_PRIO0_EN
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst             = vecs[i].rst;
            bus.req_valid   = vecs[i].val;
            bus.req_dir     = vecs[i].dir;
            bus.mem_rd_data = vecs[i].rd;
            #1;
            act   = {bus.req_ready, bus.rsp_valid[3:2] & 2'b11, 1'b0};
            act   = {bus.req_ready, bus.mem_en, bus.mem_we, bus.busy};
            exp   = {vecs[i].rdy, vecs[i].en, vecs[i].we, vecs[i].busy};
            act_d = {bus.mem_add, bus.mem_wr_data, bus.rsp_data};
            exp_d = {vecs[i].add, vecs[i].wd, vecs[i].rdat};
            n_vec++;
            if (act !== exp || bus.rsp_valid !== vecs[i].rsp || (vecs[i].chk && act_d !== exp_d))
            begin
                n_err++;
                $display("FAIL vec%0d: got rdy/en/we/busy=%b rsp=%b add/wd/rdat=%h, want %b %b %h",
                         i, act, bus.rsp_valid, act_d, exp, vecs[i].rsp, exp_d);
            end
        end
`endif

        // Continuous requests from 0 and 1: alternation, or requester 0 always with priority.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rst           = 1'b1;
            bus.req_valid = 4'hF;
            bus.req_dir   = 4'hF;
            #1;
            n_vec++;
            if ({bus.req_ready, bus.rsp_valid, bus.mem_en, bus.busy} !== 10'b0) begin
                n_err++;
                $display("FAIL reset_quiet: got rdy=%b rsp=%b en=%b busy=%b, want all 0",
                         bus.req_ready, bus.rsp_valid, bus.mem_en, bus.busy);
            end
        end
        @(negedge clk);
        rst           = 1'b0;
        bus.req_valid = 4'b0011;
        for (int g = 0; g < 6; g++) begin
            n   = 0;
            got = 1'b0;
            while (!got && n < 8) begin
                #1;
                if (bus.req_ready != 4'h0) got = 1'b1;
                else begin
                    n++;
                    @(negedge clk);
                end
            end
`ifdef IO_SCHED_PRIO0_EN
            exp_g = 4'b0001;
`else
            exp_g = (g % 2 == 0) ? 4'b0001 : 4'b0010;
`endif
            n_vec++;
            if (!got) begin
                n_err++;
                $display("FAIL grant%0d: no grant within 8 cycles, want %b", g, exp_g);
            end else if (bus.req_ready !== exp_g) begin
                n_err++;
                $display("FAIL grant%0d: got ready=%b, want %b", g, bus.req_ready, exp_g);
            end
            if (g > 0) begin
                n_vec++;
                if (n != 2) begin
                    n_err++;
                    $display("FAIL spacing%0d: got %0d idle cycles between grants, want 2", g, n);
                end
            end
            @(negedge clk);
        end
        bus.req_valid = 4'h0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/io_scheduler.md
# io_scheduler

Round-robin transaction scheduler that shares the single-port memory bus between `IO_COUNT` IO devices (VGA, keyboard, etc.) on the URISC processor. It replaces free-running time slicing with a request/ready handshake. Idle requesters are skipped, and each accepted transaction is sequenced through a small FSM: grant, memory issue, read-latency wait, response. It sits between the IO device controllers and the memory port.

## Interface
- `IO_COUNT`, default `gc::IO_COUNT`: number of requesters, ≥ 2.
- `WORD_SIZE`, default `gc::WORD_SIZE`: address and data width.
- `MEM_RD_LATENCY`, default 1: cycles from the `memEn` read cycle to valid `memRdData`, ≥ 1.

Ports:
- `clk`  in  1: single clock, all logic on posedge.
- `rst`  in  1: reset, synchronous and active-high.
- `reqValid`  in  `IO_COUNT`: per-requester request.
- `reqDir`  in  `IO_COUNT`: per-requester direction. `gc::IO_IN` = write to memory; `gc::IO_OUT` = read from memory.
- `reqAddr`  in  `[WORD_SIZE-1:0] [IO_COUNT-1:0]`: per-requester address.
- `reqData`  in  `[WORD_SIZE-1:0] [IO_COUNT-1:0]`: per-requester write data.
- `reqReady`  out  `IO_COUNT`: one-hot, 1-cycle acceptance pulse.
- `rspValid`  out  `IO_COUNT`: one-hot, 1-cycle completion pulse.
- `rspData`  out  `WORD_SIZE`: read data, shared, valid with `rspValid`.
- `busy`  out  1: FSM not in IDLE.
- `memEn`  out  1: memory access strobe.
- `memWe`  out  1: write enable, valid when `memEn`=1.
- `memAdd`  out  `WORD_SIZE`: memory address.
- `memWrData`  out  `WORD_SIZE`: memory write data.
- `memRdData`  in  `WORD_SIZE`: memory read data.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - Winner `w` = first requester with `reqValid`=1, searching from `ptr` upward and wrapping `IO_COUNT-1`→0.
  - `reqReady[w]`=1 combinationally.
  - Latch `w`, `reqDir[w]`, `reqAddr[w]`, `reqData[w]`.
  - Set `ptr` ← (w+1) mod `IO_COUNT`, and go to ISSUE.
  - No request: stay in IDLE.
- **ISSUE**: drive `memEn`=1, `memAdd`/`memWrData` from the latched values, and `memWe`=1 if the latched direction is `gc::IO_IN`.
  - Write → DONE.
  - Read with `MEM_RD_LATENCY`=1 → capture `memRdData` next cycle, then DONE.
  - Otherwise → WAIT.
- **WAIT**: down-counter loaded with `MEM_RD_LATENCY-1`. When it expires, register `memRdData` into `rspData` and go to DONE.
- **DONE**: `rspValid[w]`=1 for one cycle, then IDLE. No grant is issued in DONE.
- `rspData` holds its last read value; writes do not change it.
- Requester protocol:
  - Hold `reqValid`, `reqAddr`, `reqData`, `reqDir` stable until `reqReady`.
  - `reqValid` may stay high for back-to-back requests; it is re-arbitrated on the next IDLE.
  - Dropping `reqValid` before `reqReady` withdraws the request and is legal.
- `ptr` width is `$clog2(IO_COUNT)` (minimum 1), compared modulo `IO_COUNT`. Non-power-of-2 counts must wrap at `IO_COUNT-1`.

## Timing
- Reset values: `ptr`=0, state IDLE. `reqReady`, `rspValid`, `memEn`, `memWe`, `busy` = 0. `memAdd`, `memWrData`, `rspData` = 0.
- `rst` asserted in any state:
  - Next cycle is IDLE with no `rspValid` for the aborted transaction.
  - `memEn`=0 while `rst`=1.
  - `reqReady` is masked while `rst`=1.
- Grant at cycle T. Write: `memEn` at T+1, `rspValid` at T+2. Read: `memEn` at T+1, data sampled at T+1+L, `rspValid`/`rspData` at T+2+L.
- Throughput: one transaction per 3 cycles (write) or 3+L cycles (read).
- `busy`=1 in ISSUE, WAIT and DONE.

## Configuration
- `IO_SCHED_PRIO0_EN` defined:
  - In IDLE, requester 0 wins whenever `reqValid[0]`=1, regardless of `ptr`.
  - `ptr` is not updated on such priority grants.
  - Requests from 1..`IO_COUNT-1` remain round-robin among themselves.
- Not defined: pure round-robin over all requesters.

## Test plan
(`IO_COUNT`=4, `WORD_SIZE`=16, `MEM_RD_LATENCY`=2)
- Hold `rst` 2 cycles with all `reqValid`=4'b1111 → all outputs 0 during reset; first grant after release is `reqReady`=4'b0001.
- Requester 2 writes addr 0x0010, data 0xBEEF at T → `reqReady`=4'b0100 at T. At T+1: `memEn`=1, `memWe`=1, `memAdd`=0x0010, `memWrData`=0xBEEF. At T+2: `rspValid`=4'b0100.
- Requester 1 reads addr 0x0020, memory returns 0x1234 at T+3 → `memWe`=0 at T+1; `rspData`=0x1234 and `rspValid`=4'b0010 at T+4.
- All four writing continuously → grant order 0,1,2,3,0 with grants 3 cycles apart.
- Pointer skip: after a grant to 0, only requesters 3 and 0 valid → grant 3, then 0.
- `rst` during WAIT of a read → no `rspValid`, `memEn`=0, FSM IDLE, next grant resumes from `ptr`=0.
- With `IO_SCHED_PRIO0_EN`, requesters 0 and 1 both continuously valid → every grant goes to 0. Without the macro → grants alternate 0,1.
